mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port memory/peripheral slave between two valid/ready masters, typically instruction fetch on s0 and data access on s1. Fair round-robin grant, held until the transaction completes. Per-transaction response timeout with an error flag. Sits between the core's memory interfaces and any slave that has only one port, e.g. a single-port RAM or the dmem path feeding mem_bus_arbiter.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_rr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state encoding and default bus widths for mem_port_arbiter
package mem_port_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;
endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2: two-input round-robin pick with a registered last-winner pointer
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   req        request vector, bit X = requester X
//   upd        load the pointer with upd_id (a transaction completed)
//   upd_id     index of the requester that completed
//   pick       chosen requester index (meaningful when any=1)
//   any        at least one request is present
module rr_arbiter2 #(
    parameter bit RESET_PTR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       pick,
    output logic       any
);
    logic last;
    // Start with the pointer on the other requester so RESET_PTR wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= ~RESET_PTR;
        else if (upd) last <= upd_id;
    end
    always_comb begin
        any  = |req;
        pick = &req ? ~last : req[1];
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port valid/ready slave between two masters with round-robin grant and timeout
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   sX_valid_i/addr/wdata/we      master X request (we=0 means read)
//   sX_ready_o/rdata_o/err_o      master X completion pulse, read data, timeout error
//   m_valid_o/addr/wdata/we       request forwarded to the slave
//   m_ready_i/m_rdata_i           slave completion pulse and read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int TIMEOUT    = 256,
    parameter bit RESET_PTR  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_valid_i,
    input  logic                    s1_valid_i,
    output logic                    s0_ready_o,
    output logic                    s1_ready_o,
    input  logic [ADDR_WIDTH-1:0]   s0_addr_i,
    input  logic [ADDR_WIDTH-1:0]   s1_addr_i,
    input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
    input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s0_we_i,
    input  logic [DATA_WIDTH/8-1:0] s1_we_i,
    output logic [DATA_WIDTH-1:0]   s0_rdata_o,
    output logic [DATA_WIDTH-1:0]   s1_rdata_o,
    output logic                    s0_err_o,
    output logic                    s1_err_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_we_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t        state, nstate;
    logic [TW-1:0] tcnt;
    logic          granted, own, own_valid, tout, done, tmo, fin, pick, any;
    always_comb begin
        granted   = (state == GRANT0) || (state == GRANT1);
        own       = state == GRANT1;
        own_valid = granted && (own ? s1_valid_i : s0_valid_i);
        tout      = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
        // A slave ready in the timeout cycle takes precedence as a normal completion
        done      = own_valid && m_ready_i;
        tmo       = own_valid && !m_ready_i && tout;
        fin       = done || tmo;
    end
    rr_arbiter2 #(.RESET_PTR(RESET_PTR)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({s1_valid_i, s0_valid_i}),
        .upd    (fin),
        .upd_id (own),
        .pick   (pick),
        .any    (any)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= nstate;
            tcnt  <= (granted && nstate == state) ? tcnt + TW'(1) : '0;
        end
    end
    // Completion, timeout or an owner dropping valid all return to IDLE, which forces the bubble
    always_comb begin
        nstate = (state == IDLE) ? (any ? (pick ? GRANT1 : GRANT0) : IDLE)
               : (!granted || fin || !own_valid) ? IDLE : state;
    end
    always_comb begin
        m_valid_o  = own_valid && !tmo;
        m_addr_o   = !granted ? '0 : own ? s1_addr_i  : s0_addr_i;
        m_wdata_o  = !granted ? '0 : own ? s1_wdata_i : s0_wdata_i;
        m_we_o     = !granted ? '0 : own ? s1_we_i    : s0_we_i;
        s0_ready_o = (state == GRANT0) && fin;
        s1_ready_o = (state == GRANT1) && fin;
        s0_err_o   = (state == GRANT0) && tmo;
        s1_err_o   = (state == GRANT1) && tmo;
        s0_rdata_o = (state == GRANT0 && done) ? m_rdata_i : '0;
        s1_rdata_o = (state == GRANT1 && done) ? m_rdata_i : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va [2];
    logic [31:0] aa [2];
    logic [31:0] wa [2];
    logic [3:0]  wea [2];
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        s0_ready, s1_ready, s0_err, s1_err, m_valid;
    logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
    logic [3:0]  m_we;
    int          checks = 0;
    int          errors = 0;
    int          mo = -1;
    int          mage = 0;
    int          mlast = 1;
    logic        e_mv;
    logic [31:0] e_ma, e_mw;
    logic [3:0]  e_mwe;
    logic        e_rdy [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];
    int          order [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO), .RESET_PTR(1'b0)) dut (
        .clk(clk), .rst(rst),
        .s0_valid_i(va[0]), .s1_valid_i(va[1]),
        .s0_ready_o(s0_ready), .s1_ready_o(s1_ready),
        .s0_addr_i(aa[0]), .s1_addr_i(aa[1]),
        .s0_wdata_i(wa[0]), .s1_wdata_i(wa[1]),
        .s0_we_i(wea[0]), .s1_we_i(wea[1]),
        .s0_rdata_o(s0_rdata), .s1_rdata_o(s1_rdata),
        .s0_err_o(s0_err), .s1_err_o(s1_err),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_we_o(m_we),
        .m_rdata_i(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string p);
        chk({p, "m_valid"}, 32'(m_valid), 32'(e_mv));
        chk({p, "m_addr"}, m_addr, e_ma);
        chk({p, "m_wdata"}, m_wdata, e_mw);
        chk({p, "m_we"}, 32'(m_we), 32'(e_mwe));
        chk({p, "s0_ready"}, 32'(s0_ready), 32'(e_rdy[0]));
        chk({p, "s1_ready"}, 32'(s1_ready), 32'(e_rdy[1]));
        chk({p, "s0_err"}, 32'(s0_err), 32'(e_err[0]));
        chk({p, "s1_err"}, 32'(s1_err), 32'(e_err[1]));
        chk({p, "s0_rdata"}, s0_rdata, e_rd[0]);
        chk({p, "s1_rdata"}, s1_rdata, e_rd[1]);
    endtask

    task automatic clear_exp();
        e_mv = 1'b0; e_ma = '0; e_mw = '0; e_mwe = '0;
        for (int x = 0; x < 2; x++) begin
            e_rdy[x] = 1'b0; e_err[x] = 1'b0; e_rd[x] = '0;
        end
    endtask

    // Transaction view: an owner (or none), how long it has held the slave, and the last winner
    task automatic eval();
        int nxt;
        #1;
        clear_exp();
        nxt = mo;
        if (mo >= 0) begin
            e_ma = aa[mo]; e_mw = wa[mo]; e_mwe = wea[mo];
            if (!va[mo]) nxt = -1;
            else if (m_ready) begin
                e_mv = 1'b1; e_rdy[mo] = 1'b1; e_rd[mo] = m_rdata; mlast = mo; nxt = -1;
            end else if (mage == TO - 1) begin
                e_rdy[mo] = 1'b1; e_err[mo] = 1'b1; mlast = mo; nxt = -1;
            end else e_mv = 1'b1;
        end else if (va[0] || va[1]) begin
            nxt = (va[0] && va[1]) ? 1 - mlast : (va[0] ? 0 : 1);
        end
        mage = (mo >= 0 && nxt == mo) ? mage + 1 : 0;
        mo = nxt;
        cmp_all("");
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic reset_check(input string p);
        rst = 1'b1;
        #1;
        mo = -1; mage = 0; mlast = 1;
        clear_exp();
        cmp_all(p);
    endtask

    initial begin
        for (int x = 0; x < 2; x++) begin
            va[x] = 1'b0; aa[x] = '0; wa[x] = '0; wea[x] = '0;
        end
        m_ready = 1'b0; m_rdata = '0;
        clear_exp();
        adv();
        va[0] = 1'b1;
        reset_check("reset_");
        adv();
        rst = 1'b0; va[0] = 1'b0;

        // single read, slave answers two cycles after m_valid rises
        va[0] = 1'b1; aa[0] = 32'h100; wa[0] = 32'h0; wea[0] = 4'h0;
        eval(); chk("rd_idle_mvalid", 32'(m_valid), 32'd0); adv();
        eval(); chk("rd_mvalid_rise", 32'(m_valid), 32'd1); chk("rd_addr", m_addr, 32'h100); adv();
        eval(); adv();
        m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
        eval();
        chk("rd_ready", 32'(s0_ready), 32'd1);
        chk("rd_rdata", s0_rdata, 32'hDEADBEEF);
        chk("rd_s1_ready", 32'(s1_ready), 32'd0);
        adv();
        va[0] = 1'b0;
        eval(); chk("rd_idle_ready_ignored", 32'(s0_ready), 32'd0); adv();
        m_ready = 1'b0;

        // simultaneous requests after reset, both held: strict alternation 0,1,0,1
        reset_check("rst2_");
        adv();
        rst = 1'b0;
        va[0] = 1'b1; aa[0] = 32'h10; va[1] = 1'b1; aa[1] = 32'h20; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            eval();
            if (s0_ready) order.push_back(0);
            if (s1_ready) order.push_back(1);
            adv();
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
        va[0] = 1'b0; va[1] = 1'b0; m_ready = 1'b0;
        eval(); adv();

        // write forwarding on s1
        va[1] = 1'b1; aa[1] = 32'h8000_0004; wa[1] = 32'h1234_5678; wea[1] = 4'b0011;
        eval(); adv();
        eval();
        chk("wr_mvalid", 32'(m_valid), 32'd1);
        chk("wr_addr", m_addr, 32'h8000_0004);
        chk("wr_wdata", m_wdata, 32'h1234_5678);
        chk("wr_we", 32'(m_we), 32'h3);
        adv();
        m_ready = 1'b1;
        eval(); chk("wr_ready", 32'(s1_ready), 32'd1); chk("wr_err", 32'(s1_err), 32'd0); adv();
        va[1] = 1'b0; m_ready = 1'b0;
        eval(); adv();

        // timeout with a pending s1 served afterwards
        va[0] = 1'b1; aa[0] = 32'h200;
        eval(); adv();
        for (int i = 0; i < TO; i++) begin
            if (i == 2) begin va[1] = 1'b1; aa[1] = 32'h300; wa[1] = 32'h55; wea[1] = 4'hF; end
            eval();
            if (i < TO - 1) chk("to_early_ready", 32'(s0_ready), 32'd0);
            else begin
                chk("to_ready", 32'(s0_ready), 32'd1);
                chk("to_err", 32'(s0_err), 32'd1);
                chk("to_rdata", s0_rdata, 32'd0);
                chk("to_mvalid", 32'(m_valid), 32'd0);
            end
            adv();
        end
        va[0] = 1'b0;
        eval(); chk("to_bubble", 32'(m_valid), 32'd0); adv();
        m_ready = 1'b1; m_rdata = 32'h0BADF00D;
        eval(); chk("to_s1_served", 32'(s1_ready), 32'd1); adv();
        va[1] = 1'b0; m_ready = 1'b0;
        eval(); adv();

        // slave ready lands exactly in the timeout cycle
        va[0] = 1'b1; aa[0] = 32'h400;
        eval(); adv();
        for (int i = 0; i < TO - 1; i++) begin eval(); adv(); end
        m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
        eval();
        chk("race_ready", 32'(s0_ready), 32'd1);
        chk("race_err", 32'(s0_err), 32'd0);
        chk("race_rdata", s0_rdata, 32'hCAFEF00D);
        adv();
        va[0] = 1'b0; m_ready = 1'b0;
        eval(); adv();

        // reset in the middle of a GRANT1 transaction
        va[1] = 1'b1; aa[1] = 32'h500;
        eval(); adv();
        eval(); chk("mid_mvalid", 32'(m_valid), 32'd1);
        #2;
        reset_check("midrst_");
        adv();
        rst = 1'b0;
        va[0] = 1'b1; aa[0] = 32'h600;
        eval(); adv();
        eval(); chk("midrst_s0_wins", m_addr, 32'h600); adv();
        va[0] = 1'b0; va[1] = 1'b0;
        eval(); adv();
        eval(); adv();

        // randomized traffic, including occasional protocol-violating valid drops
        for (int n = 0; n < 1500; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (va[x] && (e_rdy[x] || $urandom_range(0, 199) == 0)) va[x] = 1'b0;
                else if (!va[x] && $urandom_range(0, 2) == 0) begin
                    va[x] = 1'b1; aa[x] = $urandom; wa[x] = $urandom; wea[x] = 4'($urandom);
                end
            end
            m_ready = ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
            eval();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
